// File: rtl/mm_line_responder.sv
// mm_line_responder: far-end main-memory model behind the L2 memory port.
// Takes one line request at a time, waits a fixed access latency, then
// returns either the line as BEATS beats or a single write-ack beat.
module mm_line_responder #(
  parameter int                     PADDR_WIDTH = 56,
  parameter logic [PADDR_WIDTH-1:0] DRAM_BASE   = 56'h8000_0000,
  parameter int                     MM_SIZE     = 16*1024*1024,
  parameter int                     LINE_SIZE   = 512,
  parameter int                     BEAT_WIDTH  = 128,
  parameter int                     LATENCY     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PADDR_WIDTH-1:0] req_addr,
  input  logic                   req_is_write,
  input  logic [LINE_SIZE-1:0]   req_wdata,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BEAT_WIDTH-1:0]  res_data,
  output logic                   res_last,
  output logic                   res_is_write,
  output logic                   res_err
);

  localparam int BEATS        = LINE_SIZE / BEAT_WIDTH;
  localparam int BEAT_W       = $clog2(BEATS);
  localparam int LINE_BYTES_W = $clog2(LINE_SIZE / 8);
  localparam int NUM_LINES    = MM_SIZE / (LINE_SIZE / 8);
  localparam int LINE_W       = $clog2(NUM_LINES);
  localparam int DEPTH        = NUM_LINES * BEATS;
  localparam logic [PADDR_WIDTH-1:0] MM_SIZE_P = PADDR_WIDTH'(MM_SIZE);
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD_BEAT, S_WR_ACK} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [LINE_W-1:0]       line_q;
  logic                    is_write_q;
  logic                    err_q;
  logic [LINE_SIZE-1:0]    wdata_q;
  logic [BEAT_WIDTH-1:0]   mem_rd_q;

  logic [PADDR_WIDTH-1:0]  off;
  logic                    req_err;
  logic                    rd_en;
  logic [BEAT_W-1:0]       rd_beat;
  logic                    mem_wr_en;

  // Backing store, one entry per beat; index = {line, beat}.
  logic [BEAT_WIDTH-1:0]   mem [0:DEPTH-1];

  // Address decode: offset into the store and out-of-range detection.
  always_comb begin
    off     = req_addr - DRAM_BASE;
    req_err = (req_addr < DRAM_BASE) || (off >= MM_SIZE_P);
  end

  // Next-state, memory enables and response outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    rd_en     = 1'b0;
    rd_beat   = beat_q;
    mem_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 8'(LATENCY);
          beat_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          if (is_write_q) begin
            state_d   = S_WR_ACK;
            // Commit the line as WR_ACK is entered; reset in the same cycle wins.
            mem_wr_en = !err_q && !rst;
          end else begin
            state_d = S_RD_BEAT;
            // Prefetch beat 0 so it is registered when RD_BEAT starts.
            rd_en   = !err_q;
            rd_beat = '0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RD_BEAT: begin
        if (res_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            rd_en   = !err_q;
            rd_beat = beat_q + 1'b1;
          end
        end
      end
      S_WR_ACK: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready    = (state_q == S_IDLE);
    res_valid    = (state_q == S_RD_BEAT) || (state_q == S_WR_ACK);
    res_last     = (state_q == S_WR_ACK) || ((state_q == S_RD_BEAT) && (beat_q == LAST_BEAT));
    res_is_write = res_valid && is_write_q;
    res_err      = res_valid && err_q;
    res_data     = ((state_q == S_RD_BEAT) && !err_q) ? mem_rd_q : '0;
  end

  // Control registers; the request is captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (req_valid && req_ready) begin
        line_q     <= off[LINE_BYTES_W +: LINE_W];
        is_write_q <= req_is_write;
        err_q      <= req_err;
        wdata_q    <= req_wdata;
      end
    end
  end

  // Store: whole-line write and registered single-beat read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int k = 0; k < BEATS; k++) begin
        mem[{line_q, BEAT_W'(k)}] <= wdata_q[k*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
    if (rd_en) begin
      mem_rd_q <= mem[{line_q, rd_beat}];
    end
  end

endmodule

// File: tb/tb_mm_line_responder.sv
// Bench for mm_line_responder: directed scenarios plus randomized traffic
// checked against a line-granular associative-array model of main memory.
module tb_mm_line_responder;

  localparam int LAT = 8;
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SIZE = 64'd16777216;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [55:0]  req_addr;
  logic         req_is_write;
  logic [511:0] req_wdata;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         res_last;
  logic         res_is_write;
  logic         res_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory: one 512-bit entry per line, keyed by byte address >> 6.
  logic [511:0] ref_mem [longint unsigned];

  mm_line_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_write(req_is_write), .req_wdata(req_wdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .res_is_write(res_is_write), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [135:0] status();
    return {res_valid, res_last, res_err, res_is_write, req_ready, 3'b000, res_data};
  endfunction

  function automatic logic [135:0] mk(input bit v, input bit l, input bit e, input bit w,
                                      input bit r, input logic [127:0] d);
    return {v, l, e, w, r, 3'b000, d};
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction, compared cycle by cycle against the model.
  task automatic txn(input logic [55:0] addr, input bit wr, input logic [511:0] wd,
                     input bit stall, input bit b2b);
    longint unsigned a;
    longint unsigned key;
    bit              err;
    logic [511:0]    line;
    logic [127:0]    exp_d;
    int              cyc;
    int              b;
    int              nb;
    bit              rr;
    a    = 64'(addr);
    key  = a >> 6;
    err  = (a < BASE) || (a >= BASE + SIZE);
    line = '0;
    if (!wr && !err && ref_mem.exists(key)) line = ref_mem[key];
    req_valid = 1'b1; req_addr = addr; req_is_write = wr; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 64) begin step(); cyc++; end
    if (b2b) chk("b2b_accept_gap", 136'(cyc), 136'(0));
    if (!req_ready) begin
      chk("accept_timeout", 136'(0), 136'(1));
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid = 1'b0; req_wdata = '0;
    cyc = 0;
    while (!res_valid && cyc < 300) begin step(); cyc++; end
    chk("latency", 136'(cyc), 136'(LAT + 1));
    nb = wr ? 1 : 4;
    b = 0; cyc = 0;
    while (b < nb && cyc < 64) begin
      rr = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      res_ready = rr;
      exp_d = (wr || err) ? 128'd0 : line[b*128 +: 128];
      chk($sformatf("%s_beat%0d_a%h", wr ? "wr" : "rd", b, addr), status(),
          mk(1'b1, wr || (b == 3), err, wr, 1'b0, exp_d));
      if (rr) b++;
      step(); cyc++;
    end
    res_ready = 1'b0;
    if (b < nb) chk("beat_timeout", 136'(b), 136'(nb));
    chk("idle_after", status(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    if (wr && !err) ref_mem[key] = wd;
  endtask

  // Reset while the third beat of a read is on the bus.
  task automatic rst_mid_read(input logic [55:0] addr);
    int cyc;
    int seen;
    logic [511:0] line;
    line = ref_mem[64'(addr) >> 6];
    req_valid = 1'b1; req_addr = addr; req_is_write = 1'b0;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 300) begin step(); cyc++; end
    res_ready = 1'b1;
    step(); step();
    chk("pre_rst_beat2", status(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, line[2*128 +: 128]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_read_out", status(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (res_valid) seen++; end
    chk("no_beats_after_rst", 136'(seen), 136'(0));
    res_ready = 1'b0;
  endtask

  // Reset during the latency wait of a write; memory must keep the old line.
  task automatic rst_mid_write(input logic [55:0] addr);
    int seen;
    req_valid = 1'b1; req_addr = addr; req_is_write = 1'b1; req_wdata = rand_line();
    step();
    req_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_write_out", status(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    seen = 0;
    res_ready = 1'b1;
    for (int i = 0; i < LAT + 6; i++) begin step(); if (res_valid) seen++; end
    res_ready = 1'b0;
    chk("no_ack_after_rst", 136'(seen), 136'(0));
  endtask

  logic [55:0] slots [6];
  logic [55:0] bad   [4];

  initial begin
    slots[0] = 56'h8000_0000; slots[1] = 56'h8000_0040; slots[2] = 56'h8000_1000;
    slots[3] = 56'h8012_3440; slots[4] = 56'h80FF_FFC0; slots[5] = 56'h80FF_FF80;
    bad[0] = 56'h7FFF_FFC0; bad[1] = 56'h8100_0000; bad[2] = 56'h0; bad[3] = 56'hFF_FFFF_FFFF_FFC0;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_is_write = 1'b0; req_wdata = '0; res_ready = 1'b0;
    repeat (3) step();
    chk("reset_state_held", status(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    rst = 1'b0;
    step();
    chk("reset_state_released", status(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));

    // Write a line, read it back through an unaligned address.
    txn(56'h8000_0040, 1'b1, rand_line(), 1'b0, 1'b0);
    txn(56'h8000_0047, 1'b0, '0, 1'b0, 1'b0);
    // Stalled read.
    txn(56'h8000_0047, 1'b0, '0, 1'b1, 1'b0);
    // Out-of-range accesses and the last valid line.
    txn(56'h80FF_FFC0, 1'b1, rand_line(), 1'b0, 1'b0);
    txn(56'h7FFF_FFC0, 1'b0, '0, 1'b0, 1'b0);
    txn(56'h8100_0000, 1'b0, '0, 1'b1, 1'b0);
    txn(56'h8100_0000, 1'b1, rand_line(), 1'b0, 1'b0);
    txn(56'h80FF_FFC0, 1'b0, '0, 1'b0, 1'b0);
    // Back-to-back reads.
    txn(56'h8000_0040, 1'b0, '0, 1'b0, 1'b0);
    txn(56'h80FF_FFC0, 1'b0, '0, 1'b0, 1'b1);
    txn(56'h8000_0040, 1'b0, '0, 1'b0, 1'b1);
    // Resets mid-transaction.
    rst_mid_read(56'h8000_0040);
    rst_mid_write(56'h80FF_FFC0);
    txn(56'h80FF_FFC0, 1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int r;
      logic [55:0] a;
      bit st;
      r  = int'($urandom_range(0, 9));
      st = 1'($urandom_range(0, 1));
      if (r < 8) begin
        a = slots[$urandom_range(0, 5)] | 56'($urandom_range(0, 63));
        if (r < 4 || !ref_mem.exists(64'(a) >> 6)) txn(a, 1'b1, rand_line(), st, 1'b0);
        else                                        txn(a, 1'b0, '0, st, 1'b0);
      end else begin
        a = bad[$urandom_range(0, 3)] | 56'($urandom_range(0, 63));
        txn(a, 1'($urandom_range(0, 1)), rand_line(), st, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
